// File: rtl/video_timing_pkg.sv
// Shared timing helpers for the video timing generator: per-axis totals,
// sync-region bounds, sync active-level mapping and the pipeline flag record.
package video_timing_pkg;

    localparam int LOOKAHEAD_MAX = 7;

    // Per-pixel decode carried down the fetch/display pipeline.
    typedef struct packed {
        logic live;
        logic active;
        logic v_blank;
        logic in_hsync;
        logic in_vsync;
        logic line_start;
        logic frame_start;
    } stage_flags_t;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

    function automatic logic active_level(input logic in_region, input int pol);
        return in_region ? (pol != 0) : (pol == 0);
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// Wrapping position counter for one video axis with active/sync region decode.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = 800,
    parameter int FP     = 40,
    parameter int SYNC   = 48,
    parameter int BP     = 40,
    parameter int W      = 10
) (
    input  logic         disp_clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         in_active,
    output logic         in_sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_S  = W'(sync_start(ACTIVE, FP));
    localparam logic [W-1:0] SYNC_E  = W'(sync_end(ACTIVE, FP, SYNC));

    always_ff @(posedge disp_clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign in_active = (count < ACT_END);
    assign in_sync   = (count >= SYNC_S) && (count < SYNC_E);

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: lead (hc,vc) counters feed a registered fetch stage,
// then a LOOKAHEAD-deep register delay line drives the display outputs.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 48,
    parameter int H_BP      = 40,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 13,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 29,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int POS_W     = 10,
    parameter int LOOKAHEAD = 2,
    parameter int FC_W      = 8
) (
    input  logic             disp_clk,
    input  logic             reset_n,
    input  logic             en,
    output logic             disp_hsync,
    output logic             disp_vsync,
    output logic             valid_draw,
    output logic             v_blank,
    output logic [POS_W-1:0] h_pos,
    output logic [POS_W-1:0] v_pos,
    output logic             line_start,
    output logic             frame_start,
    output logic             fetch_valid,
    output logic [POS_W-1:0] fetch_h,
    output logic [POS_W-1:0] fetch_v,
    output logic [FC_W-1:0]  frame_count
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > (1 << POS_W) || V_TOTAL > (1 << POS_W)) begin : g_bad_total
            $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 2**POS_W");
        end
        if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
            V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_zero
            $error("video_timing_gen: timing parameters must be non-zero");
        end
        if (LOOKAHEAD < 0 || LOOKAHEAD > LOOKAHEAD_MAX) begin : g_bad_la
            $error("video_timing_gen: LOOKAHEAD out of range 0..7");
        end
    endgenerate

    logic             run;
    logic             adv;
    logic             h_last;
    logic [POS_W-1:0] hc;
    logic [POS_W-1:0] vc;
    logic             h_act;
    logic             h_sync;
    logic             v_act;
    logic             v_sync;

    // The first enabled edge only arms the counters, holding them at (0,0).
    always_ff @(posedge disp_clk or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0;
        end else begin
            run <= en;
        end
    end

    assign adv    = en & run;
    assign h_last = (hc == POS_W'(H_TOTAL - 1));

    timing_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (POS_W)
    ) u_h_counter (
        .disp_clk  (disp_clk),
        .reset_n   (reset_n),
        .clr       (~en),
        .inc       (adv),
        .count     (hc),
        .in_active (h_act),
        .in_sync   (h_sync)
    );

    timing_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (POS_W)
    ) u_v_counter (
        .disp_clk  (disp_clk),
        .reset_n   (reset_n),
        .clr       (~en),
        .inc       (adv & h_last),
        .count     (vc),
        .in_active (v_act),
        .in_sync   (v_sync)
    );

    stage_flags_t fetch_flags;

    always_comb begin
        fetch_flags = '0;
        if (run) begin
            fetch_flags.live        = 1'b1;
            fetch_flags.active      = h_act & v_act;
            fetch_flags.v_blank     = ~v_act;
            fetch_flags.in_hsync    = h_sync;
            fetch_flags.in_vsync    = v_sync;
            fetch_flags.line_start  = (hc == '0);
            fetch_flags.frame_start = (hc == '0) && (vc == '0);
        end
    end

    // Index 0 is the fetch stage, index LOOKAHEAD is the displayed pixel.
    stage_flags_t     flags_q [LOOKAHEAD+1];
    logic [POS_W-1:0] h_q     [LOOKAHEAD+1];
    logic [POS_W-1:0] v_q     [LOOKAHEAD+1];

    always_ff @(posedge disp_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= LOOKAHEAD; k++) begin
                flags_q[k] <= '0;
                h_q[k]     <= '0;
                v_q[k]     <= '0;
            end
        end else if (!en) begin
            for (int k = 0; k <= LOOKAHEAD; k++) begin
                flags_q[k] <= '0;
                h_q[k]     <= '0;
                v_q[k]     <= '0;
            end
        end else begin
            flags_q[0] <= fetch_flags;
            h_q[0]     <= hc;
            v_q[0]     <= vc;
            for (int k = 1; k <= LOOKAHEAD; k++) begin
                flags_q[k] <= flags_q[k-1];
                h_q[k]     <= h_q[k-1];
                v_q[k]     <= v_q[k-1];
            end
        end
    end

    logic fs_next;

    generate
        if (LOOKAHEAD == 0) begin : g_fs_fetch
            assign fs_next = fetch_flags.frame_start;
        end else begin : g_fs_pipe
            assign fs_next = flags_q[LOOKAHEAD-1].frame_start;
        end
    endgenerate

    // Counted on the edge that raises frame_start; the very first one after enable is skipped.
    logic seen_first;

    always_ff @(posedge disp_clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_first  <= 1'b0;
            frame_count <= '0;
        end else if (!en) begin
            seen_first  <= 1'b0;
            frame_count <= '0;
        end else if (fs_next) begin
            if (seen_first) begin
                frame_count <= frame_count + 1'b1;
            end
            seen_first <= 1'b1;
        end
    end

    stage_flags_t disp_flags;

    assign disp_flags  = flags_q[LOOKAHEAD];
    assign disp_hsync  = disp_flags.live & active_level(disp_flags.in_hsync, HS_POL);
    assign disp_vsync  = disp_flags.live & active_level(disp_flags.in_vsync, VS_POL);
    assign valid_draw  = disp_flags.active;
    assign v_blank     = disp_flags.v_blank;
    assign line_start  = disp_flags.line_start;
    assign frame_start = disp_flags.frame_start;
    assign h_pos       = h_q[LOOKAHEAD];
    assign v_pos       = v_q[LOOKAHEAD];

    assign fetch_valid = flags_q[0].active;
    assign fetch_h     = h_q[0];
    assign fetch_v     = v_q[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a tiny 8x6 raster; expected outputs
// come from a cycles-since-enable model of the raster.
module tb_video_timing_gen;

    localparam int PW     = 10;
    localparam int FW     = 8;
    localparam int HT     = 8;
    localparam int VT     = 6;
    localparam int FRAME  = HT * VT;
    localparam int LA     = 2;
    localparam int HS_A   = 5;
    localparam int HS_B   = 6;
    localparam int VS_L   = 4;

    logic disp_clk = 1'b0;
    logic reset_n  = 1'b0;
    logic en       = 1'b0;

    logic          d_hs, d_vs, d_vd, d_vb, d_ls, d_fs, d_fv;
    logic [PW-1:0] d_hp, d_vp, d_fh, d_fvp;
    logic [FW-1:0] d_fc;
    logic          i_hs, i_vs, i_vd, i_vb, i_ls, i_fs, i_fv;
    logic [PW-1:0] i_hp, i_vp, i_fh, i_fvp;
    logic [FW-1:0] i_fc;

    always #5 disp_clk = ~disp_clk;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .POS_W(PW), .LOOKAHEAD(LA), .FC_W(FW)
    ) dut (
        .disp_clk(disp_clk), .reset_n(reset_n), .en(en),
        .disp_hsync(d_hs), .disp_vsync(d_vs), .valid_draw(d_vd), .v_blank(d_vb),
        .h_pos(d_hp), .v_pos(d_vp), .line_start(d_ls), .frame_start(d_fs),
        .fetch_valid(d_fv), .fetch_h(d_fh), .fetch_v(d_fvp), .frame_count(d_fc)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .POS_W(PW), .LOOKAHEAD(LA), .FC_W(FW)
    ) dut_inv (
        .disp_clk(disp_clk), .reset_n(reset_n), .en(en),
        .disp_hsync(i_hs), .disp_vsync(i_vs), .valid_draw(i_vd), .v_blank(i_vb),
        .h_pos(i_hp), .v_pos(i_vp), .line_start(i_ls), .frame_start(i_fs),
        .fetch_valid(i_fv), .fetch_h(i_fh), .fetch_v(i_fvp), .frame_count(i_fc)
    );

    typedef struct {
        logic          fv;
        logic [PW-1:0] fh;
        logic [PW-1:0] fvp;
        logic          vd;
        logic          vb;
        logic          hs;
        logic          vs;
        logic          hs_inv;
        logic          vs_inv;
        logic          ls;
        logic          fs;
        logic [PW-1:0] hp;
        logic [PW-1:0] vp;
        logic [FW-1:0] fc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   t      = -1;
    int   agg_vd, agg_hs, agg_vs, agg_vb, agg_hsi, agg_vsi;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, act, exp, t, $time);
        end
    endtask

    // t = edges since the first enabled edge (0 = counters armed), -1 when idle.
    function automatic exp_t model(input int tt);
        exp_t e;
        int   p, h, v;
        e = '{default: '0};
        if (tt >= 1) begin
            p = tt - 1;
            h = p % HT;
            v = (p / HT) % VT;
            e.fv  = (h < 4) && (v < 3);
            e.fh  = PW'(h);
            e.fvp = PW'(v);
        end
        if (tt >= 1 + LA) begin
            p = tt - 1 - LA;
            h = p % HT;
            v = (p / HT) % VT;
            e.vd     = (h < 4) && (v < 3);
            e.vb     = (v >= 3);
            e.hs     = !((h == HS_A) || (h == HS_B));
            e.vs     = !(v == VS_L);
            e.hs_inv = (h == HS_A) || (h == HS_B);
            e.vs_inv = (v == VS_L);
            e.hp     = PW'(h);
            e.vp     = PW'(v);
            e.ls     = (h == 0);
            e.fs     = (p % FRAME) == 0;
            e.fc     = FW'((p / FRAME) % 256);
        end
        return e;
    endfunction

    task automatic compare_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check_val("fetch_valid", 32'(d_fv),  32'(e.fv));
        check_val("fetch_h",     32'(d_fh),  32'(e.fh));
        check_val("fetch_v",     32'(d_fvp), 32'(e.fvp));
        check_val("valid_draw",  32'(d_vd),  32'(e.vd));
        check_val("v_blank",     32'(d_vb),  32'(e.vb));
        check_val("hsync",       32'(d_hs),  32'(e.hs));
        check_val("vsync",       32'(d_vs),  32'(e.vs));
        check_val("h_pos",       32'(d_hp),  32'(e.hp));
        check_val("v_pos",       32'(d_vp),  32'(e.vp));
        check_val("line_start",  32'(d_ls),  32'(e.ls));
        check_val("frame_start", 32'(d_fs),  32'(e.fs));
        check_val("frame_count", 32'(d_fc),  32'(e.fc));
        check_val("inv_hsync",   32'(i_hs),  32'(e.hs_inv));
        check_val("inv_vsync",   32'(i_vs),  32'(e.vs_inv));
        check_val("inv_vd",      32'(i_vd),  32'(e.vd));
        check_val("inv_vb",      32'(i_vb),  32'(e.vb));
        check_val("inv_pos",     32'({i_hp, i_vp}), 32'({e.hp, e.vp}));
        check_val("inv_starts",  32'({i_ls, i_fs}), 32'({e.ls, e.fs}));
        check_val("inv_fetch",   32'({i_fv, i_fh, i_fvp}), 32'({e.fv, e.fh, e.fvp}));
        check_val("inv_fc",      32'(i_fc),  32'(e.fc));
        if (d_vd)  agg_vd++;
        if (!d_hs) agg_hs++;
        if (!d_vs) agg_vs++;
        if (d_vb)  agg_vb++;
        if (i_hs)  agg_hsi++;
        if (i_vs)  agg_vsi++;
    endtask

    task automatic step(input logic en_v, input logic rst_v);
        @(negedge disp_clk);
        en      = en_v;
        reset_n = rst_v;
        if (!rst_v || !en_v) t = -1;
        else                 t = (t < 0) ? 0 : t + 1;
        sb.push_back(model(t));
        @(posedge disp_clk);
        #1;
        compare_outputs();
    endtask

    task automatic clear_agg();
        agg_vd = 0; agg_hs = 0; agg_vs = 0; agg_vb = 0; agg_hsi = 0; agg_vsi = 0;
    endtask

    task automatic mid_line_reset();
        @(posedge disp_clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("arst_vd_pos", 32'({d_vd, d_hp, d_vp}), 32'd0);
        check_val("arst_sync",   32'({d_hs, d_vs, i_hs, i_vs}), 32'd0);
        check_val("arst_flags",  32'({d_vb, d_ls, d_fs, d_fv}), 32'd0);
        check_val("arst_fetch",  32'({d_fh, d_fvp}), 32'd0);
        check_val("arst_fc",     32'(d_fc), 32'd0);
        t = -1;
        sb.delete();
    endtask

    initial begin
        clear_agg();
        repeat (3) step(1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1);

        // first frame after enable, with per-frame totals over the displayed frame
        repeat (1 + LA) step(1'b1, 1'b1);
        clear_agg();
        repeat (FRAME) step(1'b1, 1'b1);
        check_val("frame_vd_cnt",  32'(agg_vd),  32'd12);
        check_val("frame_hs_cnt",  32'(agg_hs),  32'd12);
        check_val("frame_vs_cnt",  32'(agg_vs),  32'd8);
        check_val("frame_vb_cnt",  32'(agg_vb),  32'd24);
        check_val("frame_hsi_cnt", 32'(agg_hsi), 32'd12);
        check_val("frame_vsi_cnt", 32'(agg_vsi), 32'd8);

        // enable drop at cycle 20, re-enable at cycle 30
        step(1'b0, 1'b1);
        repeat (20) step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1);
        repeat (FRAME + 3) step(1'b1, 1'b1);

        // asynchronous reset in the middle of a line
        repeat (13) step(1'b1, 1'b1);
        mid_line_reset();
        repeat (2) step(1'b1, 1'b0);

        // long run through the frame_count wrap
        for (int n = 0; n < FRAME * 257 + LA + 6; n++) begin
            step(1'b1, 1'b1);
            if (t == 1 + LA + 255 * FRAME) check_val("fc_at_255", 32'(d_fc), 32'd255);
            if (t == 1 + LA + 256 * FRAME) check_val("fc_wrap_0", 32'(d_fc), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800: active pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 40, 48, 40: horizontal porches and sync width, in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 13, 3, 29: vertical porches and sync width, in lines.
REQ-005 SHALL have parameters HS_POL, VS_POL, default 0: sync active level (0 = active-low).
REQ-006 SHALL have parameter POS_W, default 10: width of all position ports.
REQ-007 SHALL have parameter LOOKAHEAD, default 2, legal range 0..7: lead in cycles of the fetch outputs over the display outputs.
REQ-008 SHALL have parameter FC_W, default 8: width of the frame counter.
REQ-009 disp_clk  in  1  pixel clock; all logic on its rising edge.
REQ-010 reset_n  in  1  one clock; reset is asynchronous and active-low.
REQ-011 en  in  1  timing enable.
REQ-012 disp_hsync, disp_vsync  out  1  sync pulses at the polarity set by HS_POL/VS_POL.
REQ-013 valid_draw  out  1  displayed pixel is in the active region.
REQ-014 v_blank  out  1  displayed line is a vertical-blanking line.
REQ-015 h_pos, v_pos  out  POS_W  displayed pixel x/y, counted from 0.
REQ-016 line_start, frame_start  out  1  single-cycle pulses.
REQ-017 fetch_valid  out  1  lookahead pixel is active; fetch_h, fetch_v  out  POS_W  its x/y.
REQ-018 frame_count  out  FC_W  completed-frame counter.

Function
REQ-019 Horizontal order SHALL be: active [0,H_ACTIVE), front porch, sync, back porch; H_TOTAL = sum of the four. Vertical order SHALL be the same, with V_TOTAL.
REQ-020 Lead counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1) SHALL advance once per cycle while en=1: hc wraps to 0, vc increments on the hc wrap, and vc wraps to 0 after V_TOTAL-1 (frame wrap).
REQ-021 Fetch outputs SHALL be registered from (hc,vc) with 1-cycle latency: fetch_h=hc, fetch_v=vc, fetch_valid=(hc<H_ACTIVE && vc<V_ACTIVE).
REQ-022 All display outputs SHALL equal the fetch-stage values delayed by exactly LOOKAHEAD further cycles; LOOKAHEAD=0 means no added delay.
REQ-023 disp_hsync SHALL be at the active level when the displayed hc is in the sync region.
REQ-024 disp_vsync SHALL be at the active level for every pixel of lines whose vc is in the sync region, and SHALL change only at hc=0 boundaries.
REQ-025 v_blank SHALL be 1 for every pixel of lines with vc>=V_ACTIVE.
REQ-026 h_pos/v_pos SHALL be valid only while valid_draw=1; otherwise they carry the raw counts.
REQ-027 line_start SHALL pulse for 1 cycle when the displayed hc=0; frame_start SHALL pulse for 1 cycle when displayed (hc,vc)=(0,0).
REQ-028 frame_count SHALL increment, wrapping modulo 2^FC_W, in the cycle frame_start is asserted, except the first frame_start after enable.
REQ-029 en=0 SHALL synchronously zero the counters, pipeline, frame_count and all outputs (sync pins driven 0 regardless of polarity); the first cycle sampled with en=1 loads (0,0) into the lead counters.
REQ-030 en dropping mid-frame SHALL abandon the frame; re-enable SHALL restart at (0,0) with no residual pipeline data.
REQ-031 Elaboration SHALL fail if H_TOTAL or V_TOTAL exceeds 2^POS_W, any timing parameter is 0, or LOOKAHEAD>7.

Reset
REQ-032 reset_n=0 SHALL immediately force every register and output to 0, identical to the en=0 state.
REQ-033 Release of reset SHALL be followed by operation per REQ-029 on the first en=1 edge.

Structure
REQ-034 Totals, sync start/end constants and the active-level helper SHALL live in shared package video_timing_pkg.
REQ-035 One sub-module, timing_axis_counter (a wrapping counter with region decode), SHALL be instantiated once per axis.
REQ-036 The delay line SHALL be registers only, with no RAM.

Verification
Bench parameters for all scenarios below, unless stated otherwise: H=4/1/2/1, V=3/1/1/1, LOOKAHEAD=2, so H_TOTAL=8, V_TOTAL=6, 48-cycle frames.
REQ-037 en rises -> fetch_valid first at cycle 1 with (0,0); valid_draw first at cycle 3 with (0,0); frame_start=1 at cycle 3.
REQ-038 One full frame -> 12 valid_draw cycles; disp_hsync=0 for 2 cycles per line at hc=5,6; disp_vsync=0 for 8 cycles at vc=4; v_blank=1 for 24 cycles.
REQ-039 HS_POL=1, VS_POL=1 -> sync pulses inverted at identical positions.
REQ-040 en dropped at cycle 20, raised at cycle 30 -> outputs 0 in between; restart identical to REQ-037; frame_count=0.
REQ-041 reset_n pulsed low mid-line -> outputs 0 in the same cycle, without a clock edge; 256 frames, FC_W=8 -> frame_count wraps 255->0.
